decode_stage: RTL and testbench

- Pipelined, parametrised instruction decode stage for the MIPS core. Replaces single-cycle combinational decoding.
- Decodes one 32-bit instruction per cycle into a registered control bundle for the execute stage.
- Adds a valid/ready handshake, flush, and load-use hazard bubble insertion.
- Computes jump and branch targets and leaves branch resolution to execute, so decode has no dependency on the ALU zero flag.

---
 rtl/decode_stage_if.sv | 45 ++++
 rtl/decode_stage.sv | 207 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Handshake and control-bundle signals between fetch, decode_stage and execute.
interface decode_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_instr;
    logic [DATA_W-1:0]     in_pc;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_pc;
    logic [REG_ADDR_W-1:0] out_rs;
    logic [REG_ADDR_W-1:0] out_rt;
    logic [REG_ADDR_W-1:0] out_dst;
    logic [DATA_W-1:0]     out_imm;
    logic [ALU_OP_W-1:0]   out_alu_op;
    logic                  out_alu_imm_sel;
    logic                  out_mem_wren;
    logic                  out_mem_rden;
    logic                  out_reg_wren;
    logic                  out_wb_alu;
    logic                  out_link;
    logic [2:0]            out_pc_kind;
    logic [DATA_W-1:0]     out_target;
    logic                  out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_rs, out_rt, out_dst, out_imm,
               out_alu_op, out_alu_imm_sel, out_mem_wren, out_mem_rden,
               out_reg_wren, out_wb_alu, out_link, out_pc_kind, out_target,
               out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_rs, out_rt, out_dst, out_imm,
               out_alu_op, out_alu_imm_sel, out_mem_wren, out_mem_rden,
               out_reg_wren, out_wb_alu, out_link, out_pc_kind, out_target,
               out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// MIPS decode stage: one instruction per cycle into a registered control bundle,
// with valid/ready handshake, flush and load-use bubble insertion.
module decode_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 4,
    parameter bit HAZARD_EN  = 1'b1
) (
    input logic           clk,
    input logic           rst,
    decode_stage_if.slave bus
);
    localparam logic [2:0] PC_SEQ  = 3'b000;
    localparam logic [2:0] PC_JUMP = 3'b001;
    localparam logic [2:0] PC_JREG = 3'b010;
    localparam logic [2:0] PC_BEQ  = 3'b011;
    localparam logic [2:0] PC_BNE  = 3'b100;

    localparam logic [ALU_OP_W-1:0] ALU_NONE = ALU_OP_W'(4'b0000);
    localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(4'b0001);
    localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(4'b0010);
    localparam logic [ALU_OP_W-1:0] ALU_ADDU = ALU_OP_W'(4'b0011);
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = ALU_OP_W'(4'b0100);
    localparam logic [ALU_OP_W-1:0] ALU_NOR  = ALU_OP_W'(4'b0101);
    localparam logic [ALU_OP_W-1:0] ALU_SUBU = ALU_OP_W'(4'b0110);
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(4'b0111);
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = ALU_OP_W'(4'b1000);
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = ALU_OP_W'(4'b1001);
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = ALU_OP_W'(4'b1010);
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(4'b1011);
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(4'b1100);

    if (DATA_W != 32) begin : g_width_check
        $error("decode_stage: only DATA_W = 32 is supported");
    end

    typedef struct packed {
        logic [DATA_W-1:0]     pc;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] dst;
        logic [DATA_W-1:0]     imm;
        logic [ALU_OP_W-1:0]   aluOp;
        logic                  immSel;
        logic                  memWren;
        logic                  memRden;
        logic                  regWren;
        logic                  wbAlu;
        logic                  link;
        logic [2:0]            pcKind;
        logic [DATA_W-1:0]     target;
        logic                  illegal;
    } bundle_t;

    bundle_t bundle_d, bundle_q;
    logic    valid_q;
    logic    hazard;
    logic    accept;

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [DATA_W-1:0] pcPlus4;
    logic [DATA_W-1:0] immSext;
    logic [DATA_W-1:0] immZext;
    logic [DATA_W-1:0] jumpTarget;
    logic [DATA_W-1:0] branchTarget;

    assign opcode       = bus.in_instr[31:26];
    assign funct        = bus.in_instr[5:0];
    assign pcPlus4      = bus.in_pc + DATA_W'(4);
    assign immSext      = {{(DATA_W-16){bus.in_instr[15]}}, bus.in_instr[15:0]};
    assign immZext      = {{(DATA_W-16){1'b0}}, bus.in_instr[15:0]};
    assign jumpTarget   = {pcPlus4[DATA_W-1 -: 4], bus.in_instr[25:0], 2'b00};
    assign branchTarget = pcPlus4 + {immSext[DATA_W-3:0], 2'b00};

    // wbAlu defaults to 1 so every legal non-load selects the ALU path.
    always_comb begin
        bundle_d        = '0;
        bundle_d.pc     = bus.in_pc;
        bundle_d.rs     = bus.in_instr[25:21];
        bundle_d.rt     = bus.in_instr[20:16];
        bundle_d.aluOp  = ALU_NONE;
        bundle_d.pcKind = PC_SEQ;
        bundle_d.wbAlu  = 1'b1;
        case (opcode)
            6'h00: begin
                bundle_d.dst     = bus.in_instr[15:11];
                bundle_d.regWren = 1'b1;
                case (funct)
                    6'h00: bundle_d.aluOp = ALU_SLL;
                    6'h02: bundle_d.aluOp = ALU_SRL;
                    6'h03: bundle_d.aluOp = ALU_SRA;
                    6'h08: begin
                        bundle_d.pcKind  = PC_JREG;
                        bundle_d.regWren = 1'b0;
                    end
                    6'h09: begin
                        bundle_d.pcKind = PC_JREG;
                        bundle_d.link   = 1'b1;
                    end
                    6'h20: bundle_d.aluOp = ALU_ADD;
                    6'h21: bundle_d.aluOp = ALU_ADDU;
                    6'h22: bundle_d.aluOp = ALU_SUB;
                    6'h23: bundle_d.aluOp = ALU_SUBU;
                    6'h24: bundle_d.aluOp = ALU_AND;
                    6'h25: bundle_d.aluOp = ALU_OR;
                    6'h26: bundle_d.aluOp = ALU_XOR;
                    6'h27: bundle_d.aluOp = ALU_NOR;
                    6'h2A: bundle_d.aluOp = ALU_SLT;
                    default: bundle_d.illegal = 1'b1;
                endcase
            end
            6'h02: begin
                bundle_d.pcKind = PC_JUMP;
                bundle_d.target = jumpTarget;
            end
            6'h03: begin
                bundle_d.pcKind  = PC_JUMP;
                bundle_d.target  = jumpTarget;
                bundle_d.dst     = REG_ADDR_W'(31);
                bundle_d.link    = 1'b1;
                bundle_d.regWren = 1'b1;
            end
            6'h04, 6'h05: begin
                bundle_d.pcKind = (opcode == 6'h04) ? PC_BEQ : PC_BNE;
                bundle_d.target = branchTarget;
                bundle_d.aluOp  = ALU_SUB;
                bundle_d.dst    = bus.in_instr[20:16];
                bundle_d.imm    = immSext;
            end
            // Logical immediates (0x0C-0x0E) are the only zero-extended ones.
            6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E: begin
                bundle_d.dst     = bus.in_instr[20:16];
                bundle_d.immSel  = 1'b1;
                bundle_d.regWren = 1'b1;
                bundle_d.imm     = opcode[2] ? immZext : immSext;
                case (opcode)
                    6'h08:   bundle_d.aluOp = ALU_ADD;
                    6'h09:   bundle_d.aluOp = ALU_ADDU;
                    6'h0A:   bundle_d.aluOp = ALU_SLT;
                    6'h0C:   bundle_d.aluOp = ALU_AND;
                    6'h0D:   bundle_d.aluOp = ALU_OR;
                    default: bundle_d.aluOp = ALU_XOR;
                endcase
            end
            default: begin
                bundle_d.dst    = bus.in_instr[20:16];
                bundle_d.imm    = immSext;
                bundle_d.immSel = 1'b1;
                bundle_d.aluOp  = (opcode == 6'h23 || opcode == 6'h2B) ? ALU_ADD : ALU_NONE;
                if (opcode >= 6'h20 && opcode <= 6'h26) begin
                    bundle_d.memRden = 1'b1;
                    bundle_d.regWren = 1'b1;
                    bundle_d.wbAlu   = 1'b0;
                end else if (opcode >= 6'h28 && opcode <= 6'h2E) begin
                    bundle_d.memWren = 1'b1;
                end else begin
                    bundle_d.illegal = 1'b1;
                end
            end
        endcase
        if (bundle_d.illegal) begin
            bundle_d         = '0;
            bundle_d.pc      = bus.in_pc;
            bundle_d.rs      = bus.in_instr[25:21];
            bundle_d.rt      = bus.in_instr[20:16];
            bundle_d.illegal = 1'b1;
        end
    end

    assign hazard = HAZARD_EN && valid_q && bundle_q.memRden && (bundle_q.dst != '0) &&
                    (bundle_q.dst == bus.in_instr[25:21] || bundle_q.dst == bus.in_instr[20:16]);
    assign bus.in_ready = !bus.flush && (!valid_q || bus.out_ready) && !hazard;
    assign accept       = bus.in_valid && bus.in_ready;

    // Flush only clears valid; the data registers keep their last contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q  <= 1'b1;
            bundle_q <= bundle_d;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid       = valid_q;
    assign bus.out_pc          = bundle_q.pc;
    assign bus.out_rs          = bundle_q.rs;
    assign bus.out_rt          = bundle_q.rt;
    assign bus.out_dst         = bundle_q.dst;
    assign bus.out_imm         = bundle_q.imm;
    assign bus.out_alu_op      = bundle_q.aluOp;
    assign bus.out_alu_imm_sel = bundle_q.immSel;
    assign bus.out_mem_wren    = bundle_q.memWren;
    assign bus.out_mem_rden    = bundle_q.memRden;
    assign bus.out_reg_wren    = bundle_q.regWren;
    assign bus.out_wb_alu      = bundle_q.wbAlu;
    assign bus.out_link        = bundle_q.link;
    assign bus.out_pc_kind     = bundle_q.pcKind;
    assign bus.out_target      = bundle_q.target;
    assign bus.out_illegal     = bundle_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic
// against a mnemonic-level reference model and a transaction-level handshake model.
module tb_decode_stage;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] target;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic [3:0]  aluOp;
        logic [2:0]  pcKind;
        logic        immSel;
        logic        memWren;
        logic        memRden;
        logic        regWren;
        logic        wbAlu;
        logic        link;
        logic        illegal;
    } expect_t;

    logic    clk = 1'b0;
    logic    rst;
    int      checkCount = 0;
    int      errorCount = 0;
    bit      expValid;
    bit      afterReset;
    expect_t expB;

    logic [5:0] rFuncts [14] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21,
                                 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
    logic [5:0] iOps [6] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E};

    always #5 clk = ~clk;

    decode_stage_if bus ();
    decode_stage_if bus2 ();

    decode_stage #(.HAZARD_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
    decode_stage #(.HAZARD_EN(1'b0)) dutNoHazard (.clk(clk), .rst(rst), .bus(bus2));

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic string mnemonic(input logic [31:0] instr);
        logic [5:0] op;
        logic [5:0] fn;
        op = instr[31:26];
        fn = instr[5:0];
        if (op == 6'h00) begin
            case (fn)
                6'h00: return "SLL";
                6'h02: return "SRL";
                6'h03: return "SRA";
                6'h08: return "JR";
                6'h09: return "JALR";
                6'h20: return "ADD";
                6'h21: return "ADDU";
                6'h22: return "SUB";
                6'h23: return "SUBU";
                6'h24: return "AND";
                6'h25: return "OR";
                6'h26: return "XOR";
                6'h27: return "NOR";
                6'h2A: return "SLT";
                default: return "?";
            endcase
        end
        case (op)
            6'h02: return "J";
            6'h03: return "JAL";
            6'h04: return "BEQ";
            6'h05: return "BNE";
            6'h08: return "ADDI";
            6'h09: return "ADDIU";
            6'h0A: return "SLTI";
            6'h0C: return "ANDI";
            6'h0D: return "ORI";
            6'h0E: return "XORI";
            6'h23: return "LW";
            6'h2B: return "SW";
            default: begin
                if (op >= 6'h20 && op <= 6'h26) return "LOAD";
                if (op >= 6'h28 && op <= 6'h2E) return "STORE";
                return "?";
            end
        endcase
    endfunction

    function automatic logic [3:0] aluOf(input string m);
        if (m == "AND" || m == "ANDI") return 4'b0001;
        if (m == "OR" || m == "ORI") return 4'b0010;
        if (m == "ADDU" || m == "ADDIU") return 4'b0011;
        if (m == "XOR" || m == "XORI") return 4'b0100;
        if (m == "NOR") return 4'b0101;
        if (m == "SUBU") return 4'b0110;
        if (m == "SLT" || m == "SLTI") return 4'b0111;
        if (m == "SLL") return 4'b1000;
        if (m == "SRL") return 4'b1001;
        if (m == "SRA") return 4'b1010;
        if (m == "ADD" || m == "ADDI" || m == "LW" || m == "SW") return 4'b1011;
        if (m == "SUB" || m == "BEQ" || m == "BNE") return 4'b1100;
        return 4'b0000;
    endfunction

    function automatic expect_t refDecode(input logic [31:0] instr, input logic [31:0] pc);
        expect_t     e;
        string       m;
        bit          isR, isJ, isBr, isLoad, isStore;
        logic [31:0] pc4;
        m    = mnemonic(instr);
        pc4  = pc + 32'd4;
        e    = '{default: '0};
        e.pc = pc;
        e.rs = instr[25:21];
        e.rt = instr[20:16];
        if (m == "?") begin
            e.illegal = 1'b1;
            return e;
        end
        isR     = (instr[31:26] == 6'h00);
        isJ     = (m == "J") || (m == "JAL");
        isBr    = (m == "BEQ") || (m == "BNE");
        isLoad  = (m == "LW") || (m == "LOAD");
        isStore = (m == "SW") || (m == "STORE");
        e.aluOp = aluOf(m);
        if (isR) e.dst = instr[15:11];
        else if (m == "JAL") e.dst = 5'd31;
        else if (!isJ) e.dst = instr[20:16];
        if (m == "ANDI" || m == "ORI" || m == "XORI") e.imm = {16'h0000, instr[15:0]};
        else if (!isR && !isJ) e.imm = 32'($signed(instr[15:0]));
        e.immSel  = !(isR || isJ || isBr);
        e.memRden = isLoad;
        e.memWren = isStore;
        e.regWren = !(m == "JR" || m == "J" || isBr || isStore);
        e.wbAlu   = !isLoad;
        e.link    = (m == "JAL") || (m == "JALR");
        if (isJ) begin
            e.pcKind = 3'd1;
            e.target = {pc4[31:28], instr[25:0], 2'b00};
        end else if (m == "JR" || m == "JALR") begin
            e.pcKind = 3'd2;
        end else if (isBr) begin
            e.pcKind = (m == "BEQ") ? 3'd3 : 3'd4;
            e.target = pc4 + e.imm * 32'd4;
        end
        return e;
    endfunction

    function automatic logic [31:0] genInstr();
        logic [31:0] r;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  op;
        r  = $urandom;
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 9))
            0, 1, 2: return {6'h00, rs, rt, rd, r[10:6], rFuncts[$urandom_range(0, 13)]};
            3: return {iOps[$urandom_range(0, 5)], rs, rt, r[15:0]};
            4, 5: begin
                op = ($urandom_range(0, 2) == 0) ? 6'(6'h20 + $urandom_range(0, 6)) : 6'h23;
                return {op, rs, rt, r[15:0]};
            end
            6: begin
                op = ($urandom_range(0, 2) == 0) ? 6'(6'h28 + $urandom_range(0, 6)) : 6'h2B;
                return {op, rs, rt, r[15:0]};
            end
            7: return {(r[31] ? 6'h02 : 6'h03), r[25:0]};
            8: return {(r[31] ? 6'h04 : 6'h05), rs, rt, r[15:0]};
            default: begin
                case ($urandom_range(0, 2))
                    0: return {6'h3F, r[25:0]};
                    1: return {6'h10, r[25:0]};
                    default: return {6'h00, rs, rt, rd, 5'd0, 6'h01};
                endcase
            end
        endcase
    endfunction

    task automatic checkBundle();
        checkOutput("out_pc", bus.out_pc, expB.pc);
        checkOutput("out_rs", bus.out_rs, expB.rs);
        checkOutput("out_rt", bus.out_rt, expB.rt);
        checkOutput("out_dst", bus.out_dst, expB.dst);
        checkOutput("out_imm", bus.out_imm, expB.imm);
        checkOutput("out_alu_op", bus.out_alu_op, expB.aluOp);
        checkOutput("out_alu_imm_sel", bus.out_alu_imm_sel, expB.immSel);
        checkOutput("out_mem_wren", bus.out_mem_wren, expB.memWren);
        checkOutput("out_mem_rden", bus.out_mem_rden, expB.memRden);
        checkOutput("out_reg_wren", bus.out_reg_wren, expB.regWren);
        checkOutput("out_wb_alu", bus.out_wb_alu, expB.wbAlu);
        checkOutput("out_link", bus.out_link, expB.link);
        checkOutput("out_pc_kind", bus.out_pc_kind, expB.pcKind);
        checkOutput("out_target", bus.out_target, expB.target);
        checkOutput("out_illegal", bus.out_illegal, expB.illegal);
    endtask

    // One clock cycle: drive, compare against the model, advance the model, cross the edge.
    task automatic applyStimulus(input bit inValid, input logic [31:0] instr, input logic [31:0] pc,
                                 input bit fl, input bit outReady, input bit rstIn);
        bit hazard, ready;
        rst            = rstIn;
        bus.in_valid   = inValid;
        bus.in_instr   = instr;
        bus.in_pc      = pc;
        bus.flush      = fl;
        bus.out_ready  = outReady;
        #1;
        hazard = expValid && expB.memRden && (expB.dst != 5'd0) &&
                 (expB.dst == instr[25:21] || expB.dst == instr[20:16]);
        ready  = !fl && (!expValid || outReady) && !hazard;
        checkOutput("in_ready", bus.in_ready, ready);
        checkOutput("out_valid", bus.out_valid, expValid);
        if (expValid || afterReset) checkBundle();
        if (rstIn) begin
            expValid   = 1'b0;
            expB       = '{default: '0};
            afterReset = 1'b1;
        end else if (fl) begin
            expValid = 1'b0;
        end else if (inValid && ready) begin
            expB       = refDecode(instr, pc);
            expValid   = 1'b1;
            afterReset = 1'b0;
        end else if (outReady) begin
            expValid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_instr   = '0;
        bus.in_pc      = '0;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.in_instr  = '0;
        bus2.in_pc     = '0;
        bus2.flush     = 1'b0;
        bus2.out_ready = 1'b1;
        expValid       = 1'b0;
        afterReset     = 1'b1;
        expB           = '{default: '0};
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_out_valid", bus.out_valid, 32'd0);
        checkBundle();

        // ADDU $3,$1,$2
        applyStimulus(1'b1, 32'h00221821, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("addu_valid", bus.out_valid, 32'd1);
        checkOutput("addu_alu_op", bus.out_alu_op, 32'h3);
        checkOutput("addu_dst", bus.out_dst, 32'd3);
        checkOutput("addu_reg_wren", bus.out_reg_wren, 32'd1);
        checkOutput("addu_wb_alu", bus.out_wb_alu, 32'd1);
        checkOutput("addu_imm_sel", bus.out_alu_imm_sel, 32'd0);

        // LW $2,0($1) followed by a dependent ADDU: exactly one bubble
        applyStimulus(1'b1, 32'h8C220000, 32'h4, 1'b0, 1'b1, 1'b0);
        bus.in_instr = 32'h00441821;
        bus.in_pc    = 32'h8;
        #1;
        checkOutput("loaduse_in_ready", bus.in_ready, 32'd0);
        applyStimulus(1'b1, 32'h00441821, 32'h8, 1'b0, 1'b1, 1'b0);
        checkOutput("bubble_out_valid", bus.out_valid, 32'd0);
        checkOutput("bubble_then_ready", bus.in_ready, 32'd1);
        applyStimulus(1'b1, 32'h00441821, 32'h8, 1'b0, 1'b1, 1'b0);
        checkOutput("after_bubble_pc", bus.out_pc, 32'h8);
        checkOutput("after_bubble_dst", bus.out_dst, 32'd3);

        // JAL, BNE, ORI
        applyStimulus(1'b1, 32'h0C000010, 32'h00400000, 1'b0, 1'b1, 1'b0);
        checkOutput("jal_pc_kind", bus.out_pc_kind, 32'd1);
        checkOutput("jal_target", bus.out_target, 32'h00000040);
        checkOutput("jal_dst", bus.out_dst, 32'd31);
        checkOutput("jal_link", bus.out_link, 32'd1);
        checkOutput("jal_reg_wren", bus.out_reg_wren, 32'd1);
        applyStimulus(1'b1, 32'h1400FFFF, 32'h100, 1'b0, 1'b1, 1'b0);
        checkOutput("bne_pc_kind", bus.out_pc_kind, 32'd4);
        checkOutput("bne_target", bus.out_target, 32'h100);
        checkOutput("bne_reg_wren", bus.out_reg_wren, 32'd0);
        applyStimulus(1'b1, 32'h34018000, 32'h104, 1'b0, 1'b1, 1'b0);
        checkOutput("ori_imm", bus.out_imm, 32'h00008000);

        // Back-pressure for 3 cycles while XORI waits, then release
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h20010005, 32'h300, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h3842FFFF, 32'h304, 1'b0, 1'b0, 1'b0);
            checkOutput("hold_pc", bus.out_pc, 32'h300);
            checkOutput("hold_in_ready", bus.in_ready, 32'd0);
        end
        applyStimulus(1'b1, 32'h3842FFFF, 32'h304, 1'b0, 1'b1, 1'b0);
        checkOutput("release_pc", bus.out_pc, 32'h304);
        checkOutput("release_xori_imm", bus.out_imm, 32'h0000FFFF);

        // Flush while valid: offered instruction is dropped
        applyStimulus(1'b1, 32'h00A63820, 32'h400, 1'b1, 1'b0, 1'b0);
        checkOutput("flush_out_valid", bus.out_valid, 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("flush_dropped", bus.out_valid, 32'd0);

        // Illegal opcode and illegal funct
        applyStimulus(1'b1, 32'hFC000000, 32'h500, 1'b0, 1'b1, 1'b0);
        checkOutput("illegal_flag", bus.out_illegal, 32'd1);
        checkOutput("illegal_reg_wren", bus.out_reg_wren, 32'd0);
        checkOutput("illegal_mem_wren", bus.out_mem_wren, 32'd0);
        checkOutput("illegal_mem_rden", bus.out_mem_rden, 32'd0);
        checkOutput("illegal_pc_kind", bus.out_pc_kind, 32'd0);
        applyStimulus(1'b1, 32'h00000001, 32'h504, 1'b0, 1'b1, 1'b0);
        checkOutput("illegal_funct_flag", bus.out_illegal, 32'd1);

        // Reset during a hold
        applyStimulus(1'b1, 32'h24420001, 32'h600, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("midhold_reset_valid", bus.out_valid, 32'd0);
        checkOutput("midhold_reset_pc", bus.out_pc, 32'd0);

        for (int i = 0; i < 500; i++) begin
            logic [31:0] r;
            logic [31:0] pcR;
            r   = $urandom;
            pcR = $urandom;
            pcR[1:0] = 2'b00;
            applyStimulus(r[0] | r[1], genInstr(), pcR, (r[7:3] == 5'd0), (r[10:8] != 3'd0),
                          (r[20:13] == 8'd0));
        end

        // Hazard logic disabled: dependent ADDU follows LW with no bubble
        rst            = 1'b0;
        bus2.in_valid  = 1'b1;
        bus2.in_instr  = 32'h8C220000;
        bus2.in_pc     = 32'h200;
        bus2.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus2.in_instr = 32'h00441821;
        bus2.in_pc    = 32'h204;
        #1;
        checkOutput("nohaz_lw_valid", bus2.out_valid, 32'd1);
        checkOutput("nohaz_lw_rden", bus2.out_mem_rden, 32'd1);
        checkOutput("nohaz_in_ready", bus2.in_ready, 32'd1);
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        checkOutput("nohaz_addu_valid", bus2.out_valid, 32'd1);
        checkOutput("nohaz_addu_pc", bus2.out_pc, 32'h204);
        checkOutput("nohaz_addu_dst", bus2.out_dst, 32'd3);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule
